prt_dual_port: RTL and testbench
================================

PRT_DUAL_PORT -- requirements
Module: prt_dual_port

Interface
REQ-001 Parameters: DATA_WIDTH, default 8, word width; MEM_DEPTH, default 1518, words per slot; NUM_SLOTS, default 10, slot count; SLOT_W = $clog2(NUM_SLOTS); LEN_W = $clog2(MEM_DEPTH+1).
REQ-002 CLK  input  1  sole clock, rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 EN_start_writing_prt_entry / RDY_start_writing_prt_entry / start_writing_prt_entry  in 1 / out 1 / out SLOT_W  allocate slot; the allocated slot index is valid while RDY_write_prt_entry=1.
REQ-005 EN_write_prt_entry / RDY_write_prt_entry / write_prt_entry_data  in 1 / out 1 / in DATA_WIDTH  one word per enabled cycle.
REQ-006 EN_finish_writing_prt_entry / RDY_finish_writing_prt_entry  in 1 / out 1  commit packet.
REQ-007 EN_abort_writing_prt_entry / RDY_abort_writing_prt_entry  in 1 / out 1  discard packet, free slot.
REQ-008 EN_invalidate_prt_entry / RDY_invalidate_prt_entry / invalidate_prt_entry_slot  in 1 / out 1 / in SLOT_W  release a committed slot.
REQ-009 EN_start_reading_prt_entry / RDY_start_reading_prt_entry / start_reading_prt_entry_slot  in 1 / out 1 / in SLOT_W  open slot for reading.
REQ-010 EN_read_prt_entry / RDY_read_prt_entry  in 1 / out 1  request next word.
REQ-011 read_prt_entry  out DATA_WIDTH+1  {last, data}; read_prt_entry_valid  out 1  qualifies read_prt_entry.
REQ-012 is_prt_slot_free  out 1; free_slot_count  out SLOT_W+1; write_overflow  out 1  one-cycle drop pulse.

Function
REQ-013 Per-slot state SHALL be one of FREE, WRITING, VALID; each slot also holds a length of LEN_W bits.
REQ-014 The write FSM SHALL have states W_IDLE and W_ACTIVE; the read FSM SHALL have states R_IDLE and R_ACTIVE; the two FSMs SHALL operate concurrently on different slots.
REQ-015 RDY_start_writing_prt_entry = (W_IDLE && a FREE slot exists); on EN, the lowest-index FREE slot becomes WRITING, wr_ptr=0, and the FSM moves to W_ACTIVE next cycle.
REQ-016 RDY_write/finish/abort_writing = W_ACTIVE; an enabled write stores data at address slot*MEM_DEPTH+wr_ptr and increments wr_ptr.
REQ-017 A write with wr_ptr==MEM_DEPTH SHALL drop the word, leave wr_ptr unchanged, and pulse write_overflow for one cycle.
REQ-018 Finish in the same cycle as a write SHALL include that word; the slot becomes VALID with length = final wr_ptr; if length==0 the slot becomes FREE instead; the FSM returns to W_IDLE.
REQ-019 Abort SHALL return the slot to FREE and the FSM to W_IDLE; abort has priority over finish; a concurrent write is discarded.
REQ-020 RDY_start_reading_prt_entry = R_IDLE; EN on a VALID slot SHALL enter R_ACTIVE with rd_ptr=0; EN on a non-VALID slot SHALL be ignored.
REQ-021 RDY_read_prt_entry = R_ACTIVE; an enabled read SHALL fetch word rd_ptr, presented on read_prt_entry with read_prt_entry_valid=1 exactly one cycle later (registered RAM read); last=1 iff rd_ptr==length-1; after issuing the last word the FSM returns to R_IDLE.
REQ-022 RDY_invalidate_prt_entry = 1; invalidate of a VALID slot SHALL set it FREE in one cycle with no memory clearing; invalidate of a FREE or WRITING slot SHALL be ignored.
REQ-023 Invalidate of the slot being read SHALL force R_IDLE; a word already in flight is still delivered with valid=1.
REQ-024 Allocation SHALL use slot state sampled before the current edge; a slot freed by invalidate is allocatable from the next cycle.
REQ-025 free_slot_count SHALL equal the number of FREE slots, registered; is_prt_slot_free = (free_slot_count != 0).
REQ-026 Memory contents SHALL NOT be reset or cleared; reading beyond length is impossible by construction.

Reset
REQ-027 On RST_N low, asynchronously: all slots FREE, lengths 0, both FSMs idle, pointers 0, read_prt_entry_valid=0, read_prt_entry=0, write_overflow=0, and free_slot_count=NUM_SLOTS.
REQ-028 Reset mid-transaction SHALL abandon all packets; no RDY output is asserted during reset.

Structure
REQ-029 Package prt_pkg SHALL hold slot_state_t, wr_state_t, rd_state_t, and the default-parameter constants.
REQ-030 Storage SHALL be sub-module prt_mem: a simple dual-port RAM of NUM_SLOTS*MEM_DEPTH words with one write port, one read port, and registered read.

Verification
REQ-031 Reset, then start write, write 0xA1,0xB2,0xC3 and finish, start read slot 0, read 3 times -> outputs {0,A1},{0,B2},{1,C3} each one cycle after EN; free_slot_count 10->9.
REQ-032 Fill all 10 slots with 1-word packets -> RDY_start_writing_prt_entry=0 and is_prt_slot_free=0; invalidate slot 4 -> next start allocates slot 4.
REQ-033 Write MEM_DEPTH+1 words to one slot -> write_overflow pulses once; committed length is 1518; last flag on word 1517.
REQ-034 Read slot 0 while writing slot 1 on every cycle -> both data streams are intact; no stalls.
REQ-035 Finish with 0 words -> slot is FREE; abort after 5 words -> slot is FREE and start_read on it is ignored.
REQ-036 Invalidate the slot being read mid-packet -> in-flight word delivered, then RDY_read_prt_entry=0 and free_slot_count incremented.

Source files
------------

// File: rtl/prt_pkg.sv
// Shared types and default sizing for the packet-retention table (PRT).
// Slot lifecycle and the independent write/read sequencer states live here.
package prt_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MEM_DEPTH  = 1518;
  localparam int DEF_NUM_SLOTS  = 10;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WRITING = 2'd1,
    VALID   = 2'd2
  } slot_state_t;

  typedef enum logic {
    W_IDLE   = 1'b0,
    W_ACTIVE = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_ACTIVE = 1'b1
  } rd_state_t;

endpackage

// File: rtl/prt_mem.sv
// Simple dual-port packet RAM: one write port, one read port with a
// registered read; all slots share one flat array.
module prt_mem
  import prt_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_NUM_SLOTS * DEF_MEM_DEPTH,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto block RAM; only the
  // read register is reset, keeping the visible output defined.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/prt_dual_port.sv
// Packet retention table: NUM_SLOTS packet buffers, one writer and one reader
// working on different slots at the same time.
module prt_dual_port
  import prt_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter  int NUM_SLOTS  = DEF_NUM_SLOTS,
  localparam int SLOT_W     = $clog2(NUM_SLOTS),
  localparam int LEN_W      = $clog2(MEM_DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN_start_writing_prt_entry,
  output logic                  RDY_start_writing_prt_entry,
  output logic [SLOT_W-1:0]     start_writing_prt_entry,
  input  logic                  EN_write_prt_entry,
  output logic                  RDY_write_prt_entry,
  input  logic [DATA_WIDTH-1:0] write_prt_entry_data,
  input  logic                  EN_finish_writing_prt_entry,
  output logic                  RDY_finish_writing_prt_entry,
  input  logic                  EN_abort_writing_prt_entry,
  output logic                  RDY_abort_writing_prt_entry,
  input  logic                  EN_invalidate_prt_entry,
  output logic                  RDY_invalidate_prt_entry,
  input  logic [SLOT_W-1:0]     invalidate_prt_entry_slot,
  input  logic                  EN_start_reading_prt_entry,
  output logic                  RDY_start_reading_prt_entry,
  input  logic [SLOT_W-1:0]     start_reading_prt_entry_slot,
  input  logic                  EN_read_prt_entry,
  output logic                  RDY_read_prt_entry,
  output logic [DATA_WIDTH:0]   read_prt_entry,
  output logic                  read_prt_entry_valid,
  output logic                  is_prt_slot_free,
  output logic [SLOT_W:0]       free_slot_count,
  output logic                  write_overflow
);

  localparam int ADDR_W = $clog2(NUM_SLOTS * MEM_DEPTH);

  slot_state_t       slot_state     [NUM_SLOTS];
  slot_state_t       slot_state_nxt [NUM_SLOTS];
  logic [LEN_W-1:0]  slot_len       [NUM_SLOTS];
  logic [LEN_W-1:0]  slot_len_nxt   [NUM_SLOTS];

  wr_state_t         wr_state, wr_state_nxt;
  logic [SLOT_W-1:0] wr_slot, wr_slot_nxt;
  logic [LEN_W-1:0]  wr_ptr, wr_ptr_nxt;
  rd_state_t         rd_state, rd_state_nxt;
  logic [SLOT_W-1:0] rd_slot, rd_slot_nxt;
  logic [LEN_W-1:0]  rd_ptr, rd_ptr_nxt;

  logic [SLOT_W:0]   free_cnt, free_cnt_nxt;
  logic              overflow_q, overflow_nxt;
  logic              rd_valid_q, rd_last_q;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic              free_exists;
  logic [SLOT_W-1:0] alloc_slot;
  logic start_wr_fire, wr_fire, wr_full, mem_we, finish_fire, abort_fire;
  logic inv_fire, start_rd_fire, rd_fire, rd_is_last;
  logic [LEN_W-1:0]  final_len;

  function automatic logic [ADDR_W-1:0] word_addr(logic [SLOT_W-1:0] slot,
                                                  logic [LEN_W-1:0]  ptr);
    return ADDR_W'(slot) * ADDR_W'(MEM_DEPTH) + ADDR_W'(ptr);
  endfunction

  // Lowest-index FREE slot, from state registered before this edge.
  always_comb begin
    free_exists = 1'b0;
    alloc_slot  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_state[i] == FREE) begin
        free_exists = 1'b1;
        alloc_slot  = SLOT_W'(i);
      end
    end
  end

  assign RDY_start_writing_prt_entry  = RST_N && wr_state == W_IDLE && free_exists;
  assign RDY_write_prt_entry          = RST_N && wr_state == W_ACTIVE;
  assign RDY_finish_writing_prt_entry = RST_N && wr_state == W_ACTIVE;
  assign RDY_abort_writing_prt_entry  = RST_N && wr_state == W_ACTIVE;
  assign RDY_invalidate_prt_entry     = RST_N;
  assign RDY_start_reading_prt_entry  = RST_N && rd_state == R_IDLE;
  assign RDY_read_prt_entry           = RST_N && rd_state == R_ACTIVE;

  // Abort wins over finish and swallows any write in the same cycle.
  assign start_wr_fire = EN_start_writing_prt_entry && RDY_start_writing_prt_entry;
  assign abort_fire    = EN_abort_writing_prt_entry && RDY_abort_writing_prt_entry;
  assign wr_fire       = EN_write_prt_entry && RDY_write_prt_entry && !abort_fire;
  assign finish_fire   = EN_finish_writing_prt_entry && RDY_finish_writing_prt_entry
                         && !abort_fire;
  assign wr_full       = wr_ptr == LEN_W'(MEM_DEPTH);
  assign mem_we        = wr_fire && !wr_full;
  assign final_len     = wr_ptr + LEN_W'(mem_we);

  assign inv_fire = EN_invalidate_prt_entry && RDY_invalidate_prt_entry
                    && int'(invalidate_prt_entry_slot) < NUM_SLOTS
                    && slot_state[invalidate_prt_entry_slot] == VALID;

  // A start on a slot being invalidated in the same cycle is refused.
  assign start_rd_fire = EN_start_reading_prt_entry && RDY_start_reading_prt_entry
                         && int'(start_reading_prt_entry_slot) < NUM_SLOTS
                         && slot_state[start_reading_prt_entry_slot] == VALID
                         && !(inv_fire && invalidate_prt_entry_slot == start_reading_prt_entry_slot);
  assign rd_fire       = EN_read_prt_entry && RDY_read_prt_entry;
  assign rd_is_last    = rd_ptr == slot_len[rd_slot] - LEN_W'(1);

  // NOTE: every variable gets its hold value first so no path through the
  // block leaves one unassigned, which would infer a latch.
  always_comb begin
    slot_state_nxt = slot_state;
    slot_len_nxt   = slot_len;
    wr_state_nxt   = wr_state;
    wr_slot_nxt    = wr_slot;
    wr_ptr_nxt     = wr_ptr;
    rd_state_nxt   = rd_state;
    rd_slot_nxt    = rd_slot;
    rd_ptr_nxt     = rd_ptr;
    overflow_nxt   = wr_fire && wr_full;

    case (wr_state)
      W_IDLE: begin
        if (start_wr_fire) begin
          slot_state_nxt[alloc_slot] = WRITING;
          wr_slot_nxt                = alloc_slot;
          wr_ptr_nxt                 = '0;
          wr_state_nxt               = W_ACTIVE;
        end
      end
      W_ACTIVE: begin
        if (abort_fire) begin
          slot_state_nxt[wr_slot] = FREE;
          slot_len_nxt[wr_slot]   = '0;
          wr_state_nxt            = W_IDLE;
        end else begin
          wr_ptr_nxt = final_len;
          if (finish_fire) begin
            slot_state_nxt[wr_slot] = (final_len == '0) ? FREE : VALID;
            slot_len_nxt[wr_slot]   = final_len;
            wr_state_nxt            = W_IDLE;
          end
        end
      end
      default: wr_state_nxt = W_IDLE;
    endcase

    case (rd_state)
      R_IDLE: begin
        if (start_rd_fire) begin
          rd_slot_nxt  = start_reading_prt_entry_slot;
          rd_ptr_nxt   = '0;
          rd_state_nxt = R_ACTIVE;
        end
      end
      R_ACTIVE: begin
        if (rd_fire) begin
          rd_ptr_nxt = rd_ptr + LEN_W'(1);
          if (rd_is_last) rd_state_nxt = R_IDLE;
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase

    if (inv_fire) begin
      slot_state_nxt[invalidate_prt_entry_slot] = FREE;
      slot_len_nxt[invalidate_prt_entry_slot]   = '0;
      if (rd_state == R_ACTIVE && rd_slot == invalidate_prt_entry_slot)
        rd_state_nxt = R_IDLE;
    end

    free_cnt_nxt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_state_nxt[i] == FREE) free_cnt_nxt = free_cnt_nxt + (SLOT_W + 1)'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_state[i] <= FREE;
        slot_len[i]   <= '0;
      end
      wr_state   <= W_IDLE;
      wr_slot    <= '0;
      wr_ptr     <= '0;
      rd_state   <= R_IDLE;
      rd_slot    <= '0;
      rd_ptr     <= '0;
      free_cnt   <= (SLOT_W + 1)'(NUM_SLOTS);
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      slot_state <= slot_state_nxt;
      slot_len   <= slot_len_nxt;
      wr_state   <= wr_state_nxt;
      wr_slot    <= wr_slot_nxt;
      wr_ptr     <= wr_ptr_nxt;
      rd_state   <= rd_state_nxt;
      rd_slot    <= rd_slot_nxt;
      rd_ptr     <= rd_ptr_nxt;
      free_cnt   <= free_cnt_nxt;
      overflow_q <= overflow_nxt;
      rd_valid_q <= rd_fire;
      if (rd_fire) rd_last_q <= rd_is_last;
    end
  end

  prt_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NUM_SLOTS * MEM_DEPTH)
  ) u_mem (
    .clk   (CLK),
    .rst_n (RST_N),
    .we    (mem_we),
    .waddr (word_addr(wr_slot, wr_ptr)),
    .wdata (write_prt_entry_data),
    .re    (rd_fire),
    .raddr (word_addr(rd_slot, rd_ptr)),
    .rdata (mem_rdata)
  );

  assign start_writing_prt_entry = wr_slot;
  assign read_prt_entry          = {rd_last_q, mem_rdata};
  assign read_prt_entry_valid    = rd_valid_q;
  assign free_slot_count         = free_cnt;
  assign is_prt_slot_free        = free_cnt != '0;
  assign write_overflow          = overflow_q;

endmodule

// File: tb/tb_prt_dual_port.sv
// Self-checking bench for prt_dual_port against a slot/queue reference model.
module tb_prt_dual_port;

  localparam int DW = 8;
  localparam int MD = 1518;
  localparam int NS = 10;
  localparam int SW = 4;
  localparam int M_FREE = 0, M_WR = 1, M_VAL = 2;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          EN_start_writing_prt_entry = 1'b0;
  logic          RDY_start_writing_prt_entry;
  logic [SW-1:0] start_writing_prt_entry;
  logic          EN_write_prt_entry = 1'b0;
  logic          RDY_write_prt_entry;
  logic [DW-1:0] write_prt_entry_data = '0;
  logic          EN_finish_writing_prt_entry = 1'b0;
  logic          RDY_finish_writing_prt_entry;
  logic          EN_abort_writing_prt_entry = 1'b0;
  logic          RDY_abort_writing_prt_entry;
  logic          EN_invalidate_prt_entry = 1'b0;
  logic          RDY_invalidate_prt_entry;
  logic [SW-1:0] invalidate_prt_entry_slot = '0;
  logic          EN_start_reading_prt_entry = 1'b0;
  logic          RDY_start_reading_prt_entry;
  logic [SW-1:0] start_reading_prt_entry_slot = '0;
  logic          EN_read_prt_entry = 1'b0;
  logic          RDY_read_prt_entry;
  logic [DW:0]   read_prt_entry;
  logic          read_prt_entry_valid;
  logic          is_prt_slot_free;
  logic [SW:0]   free_slot_count;
  logic          write_overflow;

  int errors = 0;
  int checks = 0;

  // Reference model: slot state plus the words each slot holds.
  int            mstate [NS];
  logic [DW-1:0] mdata  [NS][$];
  int            cur_wr = 0;

  always #5 CLK = ~CLK;

  prt_dual_port #(.DATA_WIDTH(DW), .MEM_DEPTH(MD), .NUM_SLOTS(NS)) dut (
    .CLK                          (CLK),
    .RST_N                        (RST_N),
    .EN_start_writing_prt_entry   (EN_start_writing_prt_entry),
    .RDY_start_writing_prt_entry  (RDY_start_writing_prt_entry),
    .start_writing_prt_entry      (start_writing_prt_entry),
    .EN_write_prt_entry           (EN_write_prt_entry),
    .RDY_write_prt_entry          (RDY_write_prt_entry),
    .write_prt_entry_data         (write_prt_entry_data),
    .EN_finish_writing_prt_entry  (EN_finish_writing_prt_entry),
    .RDY_finish_writing_prt_entry (RDY_finish_writing_prt_entry),
    .EN_abort_writing_prt_entry   (EN_abort_writing_prt_entry),
    .RDY_abort_writing_prt_entry  (RDY_abort_writing_prt_entry),
    .EN_invalidate_prt_entry      (EN_invalidate_prt_entry),
    .RDY_invalidate_prt_entry     (RDY_invalidate_prt_entry),
    .invalidate_prt_entry_slot    (invalidate_prt_entry_slot),
    .EN_start_reading_prt_entry   (EN_start_reading_prt_entry),
    .RDY_start_reading_prt_entry  (RDY_start_reading_prt_entry),
    .start_reading_prt_entry_slot (start_reading_prt_entry_slot),
    .EN_read_prt_entry            (EN_read_prt_entry),
    .RDY_read_prt_entry           (RDY_read_prt_entry),
    .read_prt_entry               (read_prt_entry),
    .read_prt_entry_valid         (read_prt_entry_valid),
    .is_prt_slot_free             (is_prt_slot_free),
    .free_slot_count              (free_slot_count),
    .write_overflow               (write_overflow)
  );

  function automatic int m_lowest_free();
    for (int i = 0; i < NS; i++) if (mstate[i] == M_FREE) return i;
    return -1;
  endfunction

  function automatic int m_free_count();
    int n = 0;
    for (int i = 0; i < NS; i++) if (mstate[i] == M_FREE) n++;
    return n;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NS; i++) begin
      mstate[i] = M_FREE;
      mdata[i].delete();
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start_write(output int slot);
    int exp = m_lowest_free();
    checks++;
    if (RDY_start_writing_prt_entry !== (exp >= 0)) begin
      errors++; $display("FAIL start_rdy got=%0b exp=%0b", RDY_start_writing_prt_entry, exp >= 0);
    end
    slot = exp;
    if (exp < 0) return;
    EN_start_writing_prt_entry = 1'b1; tick(); EN_start_writing_prt_entry = 1'b0;
    checks++;
    if (RDY_write_prt_entry !== 1'b1 || int'(start_writing_prt_entry) != exp) begin
      errors++; $display("FAIL alloc_slot got=%0d rdy=%0b exp=%0d", start_writing_prt_entry, RDY_write_prt_entry, exp);
    end
    mstate[exp] = M_WR;
    mdata[exp].delete();
    cur_wr = exp;
  endtask

  task automatic do_write(input logic [DW-1:0] d);
    bit drop = (mdata[cur_wr].size() >= MD);
    EN_write_prt_entry = 1'b1; write_prt_entry_data = d;
    tick();
    EN_write_prt_entry = 1'b0;
    if (!drop) mdata[cur_wr].push_back(d);
    checks++;
    if (write_overflow !== drop) begin
      errors++; $display("FAIL overflow_flag got=%0b exp=%0b len=%0d", write_overflow, drop, mdata[cur_wr].size());
    end
  endtask

  task automatic do_finish();
    EN_finish_writing_prt_entry = 1'b1; tick(); EN_finish_writing_prt_entry = 1'b0;
    mstate[cur_wr] = (mdata[cur_wr].size() == 0) ? M_FREE : M_VAL;
    checks++;
    if (free_slot_count !== (SW+1)'(m_free_count()) || RDY_write_prt_entry !== 1'b0) begin
      errors++; $display("FAIL finish_count got=%0d exp=%0d rdy_wr=%0b", free_slot_count, m_free_count(), RDY_write_prt_entry);
    end
  endtask

  // Abort with finish and write asserted alongside: abort must win.
  task automatic do_abort();
    EN_abort_writing_prt_entry = 1'b1; EN_finish_writing_prt_entry = 1'b1;
    EN_write_prt_entry = 1'b1; write_prt_entry_data = 8'($urandom);
    tick();
    EN_abort_writing_prt_entry = 1'b0; EN_finish_writing_prt_entry = 1'b0; EN_write_prt_entry = 1'b0;
    mstate[cur_wr] = M_FREE;
    mdata[cur_wr].delete();
    checks++;
    if (free_slot_count !== (SW+1)'(m_free_count()) || RDY_write_prt_entry !== 1'b0) begin
      errors++; $display("FAIL abort_count got=%0d exp=%0d", free_slot_count, m_free_count());
    end
  endtask

  task automatic do_invalidate(input int slot);
    EN_invalidate_prt_entry = 1'b1; invalidate_prt_entry_slot = SW'(slot);
    tick();
    EN_invalidate_prt_entry = 1'b0;
    if (mstate[slot] == M_VAL) begin
      mstate[slot] = M_FREE;
      mdata[slot].delete();
    end
    checks++;
    if (free_slot_count !== (SW+1)'(m_free_count())) begin
      errors++; $display("FAIL inv_count slot=%0d got=%0d exp=%0d", slot, free_slot_count, m_free_count());
    end
  endtask

  task automatic do_read_packet(input int slot);
    bit ok = (mstate[slot] == M_VAL);
    int n = mdata[slot].size();
    logic [DW:0] exp;
    checks++;
    if (RDY_start_reading_prt_entry !== 1'b1) begin
      errors++; $display("FAIL start_rd_rdy got=%0b exp=1", RDY_start_reading_prt_entry);
    end
    EN_start_reading_prt_entry = 1'b1; start_reading_prt_entry_slot = SW'(slot);
    tick();
    EN_start_reading_prt_entry = 1'b0;
    checks++;
    if (RDY_read_prt_entry !== ok) begin
      errors++; $display("FAIL rd_open slot=%0d got=%0b exp=%0b", slot, RDY_read_prt_entry, ok);
    end
    if (!ok) return;
    EN_read_prt_entry = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      exp = {(i == n - 1), mdata[slot][i]};
      checks++;
      if (read_prt_entry_valid !== 1'b1 || read_prt_entry !== exp) begin
        errors++; $display("FAIL rd_word slot=%0d idx=%0d got=%0h v=%0b exp=%0h", slot, i, read_prt_entry, read_prt_entry_valid, exp);
      end
    end
    EN_read_prt_entry = 1'b0;
    checks++;
    if (RDY_read_prt_entry !== 1'b0) begin
      errors++; $display("FAIL rd_end_rdy got=%0b exp=0", RDY_read_prt_entry);
    end
    tick();
    checks++;
    if (read_prt_entry_valid !== 1'b0) begin
      errors++; $display("FAIL rd_valid_drop got=%0b exp=0", read_prt_entry_valid);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    m_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({RDY_start_writing_prt_entry, RDY_write_prt_entry, RDY_finish_writing_prt_entry,
         RDY_abort_writing_prt_entry, RDY_invalidate_prt_entry, RDY_start_reading_prt_entry,
         RDY_read_prt_entry} !== 7'b0) begin
      errors++; $display("FAIL reset_rdy some RDY asserted during reset");
    end
    checks++;
    if (free_slot_count !== (SW+1)'(NS) || read_prt_entry !== '0 || read_prt_entry_valid !== 1'b0
        || write_overflow !== 1'b0) begin
      errors++; $display("FAIL reset_outs cnt=%0d rd=%0h v=%0b ovf=%0b", free_slot_count, read_prt_entry, read_prt_entry_valid, write_overflow);
    end
    RST_N = 1'b1;
    tick();
    checks++;
    if (RDY_start_writing_prt_entry !== 1'b1 || RDY_invalidate_prt_entry !== 1'b1
        || RDY_start_reading_prt_entry !== 1'b1 || RDY_write_prt_entry !== 1'b0
        || is_prt_slot_free !== 1'b1) begin
      errors++; $display("FAIL post_reset_rdy sw=%0b inv=%0b sr=%0b wr=%0b", RDY_start_writing_prt_entry, RDY_invalidate_prt_entry, RDY_start_reading_prt_entry, RDY_write_prt_entry);
    end
  endtask

  task automatic test_basic();
    int s;
    do_start_write(s);
    do_write(8'hA1); do_write(8'hB2); do_write(8'hC3);
    do_finish();
    checks++;
    if (free_slot_count !== 5'd9) begin
      errors++; $display("FAIL basic_count got=%0d exp=9", free_slot_count);
    end
    do_read_packet(0);
  endtask

  task automatic test_fill();
    int s;
    for (int i = 0; i < NS - 1; i++) begin
      do_start_write(s);
      do_write(8'($urandom));
      do_finish();
    end
    checks++;
    if (RDY_start_writing_prt_entry !== 1'b0 || is_prt_slot_free !== 1'b0) begin
      errors++; $display("FAIL full rdy=%0b free=%0b exp 0/0", RDY_start_writing_prt_entry, is_prt_slot_free);
    end
    EN_invalidate_prt_entry = 1'b1; invalidate_prt_entry_slot = SW'(4);
    #1;
    checks++;
    if (RDY_start_writing_prt_entry !== 1'b0) begin
      errors++; $display("FAIL same_cycle_alloc got=%0b exp=0", RDY_start_writing_prt_entry);
    end
    tick();
    EN_invalidate_prt_entry = 1'b0;
    mstate[4] = M_FREE; mdata[4].delete();
    checks++;
    if (RDY_start_writing_prt_entry !== 1'b1 || free_slot_count !== 5'd1) begin
      errors++; $display("FAIL freed_slot rdy=%0b cnt=%0d", RDY_start_writing_prt_entry, free_slot_count);
    end
    do_start_write(s);
    checks++;
    if (s != 4) begin
      errors++; $display("FAIL realloc got=%0d exp=4", s);
    end
    do_write(8'h5A);
    do_finish();
    do_read_packet(4);
    for (int i = 0; i < NS; i++) do_invalidate(i);
  endtask

  task automatic test_overflow();
    int s;
    int pulses = 0;
    do_start_write(s);
    for (int i = 0; i < MD + 1; i++) begin
      do_write(8'($urandom));
      if (write_overflow === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL overflow_pulses got=%0d exp=1", pulses);
    end
    do_finish();
    do_read_packet(s);
    do_invalidate(s);
  endtask

  task automatic test_concurrent();
    int s0;
    logic [DW:0] exp;
    do_start_write(s0);
    for (int i = 0; i < 20; i++) do_write(8'($urandom));
    do_finish();
    EN_start_writing_prt_entry = 1'b1;
    EN_start_reading_prt_entry = 1'b1; start_reading_prt_entry_slot = SW'(s0);
    tick();
    EN_start_writing_prt_entry = 1'b0; EN_start_reading_prt_entry = 1'b0;
    cur_wr = m_lowest_free();
    mstate[cur_wr] = M_WR; mdata[cur_wr].delete();
    checks++;
    if (RDY_write_prt_entry !== 1'b1 || RDY_read_prt_entry !== 1'b1
        || int'(start_writing_prt_entry) != cur_wr) begin
      errors++; $display("FAIL dual_open wr=%0b rd=%0b slot=%0d exp=%0d", RDY_write_prt_entry, RDY_read_prt_entry, start_writing_prt_entry, cur_wr);
    end
    for (int i = 0; i < 20; i++) begin
      EN_write_prt_entry = 1'b1; write_prt_entry_data = 8'($urandom);
      EN_read_prt_entry = 1'b1;
      mdata[cur_wr].push_back(write_prt_entry_data);
      tick();
      exp = {(i == 19), mdata[s0][i]};
      checks++;
      if (read_prt_entry_valid !== 1'b1 || read_prt_entry !== exp || RDY_write_prt_entry !== 1'b1) begin
        errors++; $display("FAIL concurrent idx=%0d got=%0h v=%0b exp=%0h", i, read_prt_entry, read_prt_entry_valid, exp);
      end
    end
    EN_write_prt_entry = 1'b0; EN_read_prt_entry = 1'b0;
    do_finish();
    do_read_packet(cur_wr);
    do_invalidate(s0);
    do_invalidate(1);
  endtask

  task automatic test_zero_abort();
    int s;
    do_start_write(s);
    do_finish();
    checks++;
    if (free_slot_count !== 5'd10) begin
      errors++; $display("FAIL empty_finish cnt=%0d exp=10", free_slot_count);
    end
    do_read_packet(s);
    do_start_write(s);
    for (int i = 0; i < 5; i++) do_write(8'($urandom));
    do_abort();
    do_read_packet(s);
  endtask

  task automatic test_inv_mid_read();
    int s;
    logic [DW:0] exp;
    do_start_write(s);
    for (int i = 0; i < 8; i++) do_write(8'($urandom));
    do_finish();
    EN_start_reading_prt_entry = 1'b1; start_reading_prt_entry_slot = SW'(s);
    tick();
    EN_start_reading_prt_entry = 1'b0;
    EN_read_prt_entry = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = {1'b0, mdata[s][i]};
      checks++;
      if (read_prt_entry_valid !== 1'b1 || read_prt_entry !== exp) begin
        errors++; $display("FAIL pre_inv idx=%0d got=%0h exp=%0h", i, read_prt_entry, exp);
      end
    end
    EN_invalidate_prt_entry = 1'b1; invalidate_prt_entry_slot = SW'(s);
    tick();
    EN_invalidate_prt_entry = 1'b0; EN_read_prt_entry = 1'b0;
    exp = {1'b0, mdata[s][3]};
    mstate[s] = M_FREE; mdata[s].delete();
    checks++;
    if (read_prt_entry_valid !== 1'b1 || read_prt_entry !== exp || RDY_read_prt_entry !== 1'b0
        || free_slot_count !== (SW+1)'(m_free_count())) begin
      errors++; $display("FAIL inv_in_flight got=%0h v=%0b rdy=%0b cnt=%0d exp=%0h", read_prt_entry, read_prt_entry_valid, RDY_read_prt_entry, free_slot_count, exp);
    end
    tick();
    checks++;
    if (read_prt_entry_valid !== 1'b0) begin
      errors++; $display("FAIL inv_after got v=%0b exp=0", read_prt_entry_valid);
    end
    do_read_packet(s);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int op = int'($urandom_range(0, 2));
      if (op == 0 && m_lowest_free() >= 0) begin
        int s;
        int len = int'($urandom_range(0, 12));
        do_start_write(s);
        for (int k = 0; k < len; k++) do_write(8'($urandom));
        if ($urandom_range(0, 5) == 0) do_abort();
        else do_finish();
      end else if (op == 1) begin
        do_read_packet(int'($urandom_range(0, NS - 1)));
      end else begin
        do_invalidate(int'($urandom_range(0, NS - 1)));
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < NS; i++) do_invalidate(i);
    begin
      int s;
      do_start_write(s);
      do_write(8'h11); do_write(8'h22);
    end
    #3 RST_N = 1'b0;
    #1;
    checks++;
    if (RDY_write_prt_entry !== 1'b0 || RDY_invalidate_prt_entry !== 1'b0
        || free_slot_count !== (SW+1)'(NS)) begin
      errors++; $display("FAIL async_reset wr=%0b inv=%0b cnt=%0d", RDY_write_prt_entry, RDY_invalidate_prt_entry, free_slot_count);
    end
    m_reset();
    tick();
    RST_N = 1'b1;
    tick();
    do_read_packet(0);
    begin
      int s;
      do_start_write(s);
      do_write(8'h33);
      do_finish();
      do_read_packet(s);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_overflow();
    test_concurrent();
    test_zero_abort();
    test_inv_mid_read();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
